// File: rtl/cpu_ctrl_pkg.sv
// Control-bundle bit positions, MIPS opcode/function codes and the legality table
// shared by the decode-stage queue and its combinational decoder.
package cpu_ctrl_pkg;

  localparam int SIG_REGDST    = 0;
  localparam int SIG_BRANCH    = 1;
  localparam int SIG_JMP       = 2;
  localparam int SIG_MEMTOREG  = 3;
  localparam int SIG_MEMREAD   = 4;
  localparam int SIG_MEMWRITE  = 5;
  localparam int SIG_ALUSRC    = 6;
  localparam int SIG_REGWRITE  = 7;
  localparam int SIG_ALUOP_LO  = 8;
  localparam int SIG_X_SRC_R2  = 12;
  localparam int SIG_JAL       = 13;
  localparam int SIG_JR        = 14;
  localparam int SIG_SYSCALL   = 15;
  localparam int SIG_MFC0      = 16;
  localparam int SIG_MTC0      = 17;
  localparam int SIG_ERET      = 18;
  localparam int SIG_BSEL_LO   = 19;
  localparam int SIG_LH        = 21;
  localparam int CTRL_W        = 22;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNC_SLL     = 6'h00;
  localparam logic [5:0] FUNC_SRL     = 6'h02;
  localparam logic [5:0] FUNC_SRA     = 6'h03;
  localparam logic [5:0] FUNC_JR      = 6'h08;
  localparam logic [5:0] FUNC_SYSCALL = 6'h0C;
  localparam logic [5:0] FUNC_ERET    = 6'h18;
  localparam logic [5:0] FUNC_ADD     = 6'h20;
  localparam logic [5:0] FUNC_ADDU    = 6'h21;
  localparam logic [5:0] FUNC_SUB     = 6'h22;
  localparam logic [5:0] FUNC_SUBU    = 6'h23;
  localparam logic [5:0] FUNC_AND     = 6'h24;
  localparam logic [5:0] FUNC_OR      = 6'h25;
  localparam logic [5:0] FUNC_XOR     = 6'h26;
  localparam logic [5:0] FUNC_NOR     = 6'h27;
  localparam logic [5:0] FUNC_SLT     = 6'h2A;
  localparam logic [5:0] FUNC_SLTU    = 6'h2B;

  localparam logic [4:0] COP0_MF = 5'h00;
  localparam logic [4:0] COP0_MT = 5'h04;
  localparam logic [4:0] COP0_CO = 5'h10;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_NOR  = 4'd3,
    ALU_ADD  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_LUI  = 4'd12
  } alu_op_e;

  typedef struct packed {
    logic              legal;
    logic [CTRL_W-1:0] sig;
  } ctrl_t;

  function automatic logic [CTRL_W-1:0] bit_of(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

  function automatic logic [CTRL_W-1:0] alu_field(input alu_op_e op);
    return CTRL_W'(op) << SIG_ALUOP_LO;
  endfunction

  function automatic logic [CTRL_W-1:0] rtype(input alu_op_e op);
    return bit_of(SIG_REGDST) | bit_of(SIG_REGWRITE) | alu_field(op);
  endfunction

  function automatic logic [CTRL_W-1:0] itype(input alu_op_e op);
    return bit_of(SIG_ALUSRC) | bit_of(SIG_REGWRITE) | alu_field(op);
  endfunction

  // Legality table: anything not listed decodes to an all-zero bundle with legal=0.
  function automatic ctrl_t ctrl_table(input logic [31:0] ir);
    ctrl_t      c;
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rs;
    op      = ir[31:26];
    func    = ir[5:0];
    rs      = ir[25:21];
    c.legal = 1'b1;
    c.sig   = '0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FUNC_ADD, FUNC_ADDU: c.sig = rtype(ALU_ADD);
          FUNC_SUB, FUNC_SUBU: c.sig = rtype(ALU_SUB);
          FUNC_AND:            c.sig = rtype(ALU_AND);
          FUNC_OR:             c.sig = rtype(ALU_OR);
          FUNC_XOR:            c.sig = rtype(ALU_XOR);
          FUNC_NOR:            c.sig = rtype(ALU_NOR);
          FUNC_SLT:            c.sig = rtype(ALU_SLT);
          FUNC_SLTU:           c.sig = rtype(ALU_SLTU);
          FUNC_SLL:            c.sig = rtype(ALU_SLL);
          FUNC_SRL:            c.sig = rtype(ALU_SRL);
          FUNC_SRA:            c.sig = rtype(ALU_SRA);
          FUNC_JR:             c.sig = bit_of(SIG_JMP) | bit_of(SIG_JR);
          FUNC_SYSCALL:        c.sig = bit_of(SIG_SYSCALL);
          default:             c.legal = 1'b0;
        endcase
      end
      OP_J:     c.sig = bit_of(SIG_JMP);
      OP_JAL:   c.sig = bit_of(SIG_JMP) | bit_of(SIG_REGWRITE) | bit_of(SIG_JAL);
      OP_BEQ:   c.sig = bit_of(SIG_BRANCH) | alu_field(ALU_SUB);
      OP_BNE:   c.sig = bit_of(SIG_BRANCH) | alu_field(ALU_SUB) | bit_of(SIG_BSEL_LO);
      OP_ADDI, OP_ADDIU: c.sig = itype(ALU_ADD);
      OP_SLTI:  c.sig = itype(ALU_SLT);
      OP_ANDI:  c.sig = itype(ALU_AND);
      OP_ORI:   c.sig = itype(ALU_OR);
      OP_XORI:  c.sig = itype(ALU_XOR);
      OP_LUI:   c.sig = itype(ALU_LUI);
      OP_LW:    c.sig = itype(ALU_ADD) | bit_of(SIG_MEMTOREG) | bit_of(SIG_MEMREAD);
      OP_LH:    c.sig = itype(ALU_ADD) | bit_of(SIG_MEMTOREG) | bit_of(SIG_MEMREAD) | bit_of(SIG_LH);
      OP_SW:    c.sig = bit_of(SIG_ALUSRC) | bit_of(SIG_MEMWRITE) | alu_field(ALU_ADD);
      OP_COP0: begin
        if (rs == COP0_MF)
          c.sig = bit_of(SIG_REGWRITE) | bit_of(SIG_MFC0);
        else if (rs == COP0_MT)
          c.sig = bit_of(SIG_MTC0) | bit_of(SIG_X_SRC_R2);
        else if (rs == COP0_CO && func == FUNC_ERET)
          c.sig = bit_of(SIG_ERET);
        else
          c.legal = 1'b0;
      end
      default:  c.legal = 1'b0;
    endcase
    if (!c.legal) c.sig = '0;
    return c;
  endfunction

endpackage

// File: rtl/ir_ctrl_decode.sv
// Pure combinational instruction decoder: instruction word -> control bundle,
// illegal flag and trap flag (syscall, eret or illegal).
module ir_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int SIG_W = 32
) (
  input  logic [31:0]      ir,
  output logic [SIG_W-1:0] signal,
  output logic             illegal,
  output logic             trap
);

  ctrl_t ctrl;

  assign ctrl    = ctrl_table(ir);
  assign signal  = SIG_W'(ctrl.sig);
  assign illegal = !ctrl.legal;
  assign trap    = ctrl.sig[SIG_SYSCALL] | ctrl.sig[SIG_ERET] | !ctrl.legal;

endmodule

// File: rtl/ir_decode_queue.sv
// Decode-stage front end: circular instruction queue feeding a registered,
// decoded output slot, with trap serialisation and pipeline flush.
module ir_decode_queue
  import cpu_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int SIG_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_ir,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_ir,
  output logic [PC_W-1:0]          out_pc,
  output logic [SIG_W-1:0]         out_signal,
  output logic                     out_illegal,
  output logic                     out_trap,
  output logic                     trap_hold,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      ir_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [31:0]      head_ir;
  logic [SIG_W-1:0] head_signal;
  logic             head_illegal;
  logic             head_trap;
  logic             push;
  logic             load;
  logic             out_fire;

  assign head_ir = ir_mem[rd_ptr];

  ir_ctrl_decode #(.SIG_W(SIG_W)) u_decode (
    .ir      (head_ir),
    .signal  (head_signal),
    .illegal (head_illegal),
    .trap    (head_trap)
  );

  // No full pass-through: a pop in the same cycle does not open the queue.
  assign in_ready = (count != FULL) && !rst;
  assign push     = in_valid && in_ready && !flush;
  assign out_fire = out_valid && out_ready;
  // A trap leaving the output slot must also block the load racing it that cycle.
  assign load     = (count != '0) && !trap_hold && (!out_valid || out_ready)
                    && !(out_fire && out_trap);

  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[wr_ptr] <= in_ir;
      pc_mem[wr_ptr] <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_ir      <= '0;
      out_pc      <= '0;
      out_signal  <= '0;
      out_illegal <= 1'b0;
      out_trap    <= 1'b0;
      trap_hold   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) begin
        out_valid   <= 1'b1;
        out_ir      <= head_ir;
        out_pc      <= pc_mem[rd_ptr];
        out_signal  <= head_signal;
        out_illegal <= head_illegal;
        out_trap    <= head_trap;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire && out_trap) trap_hold <= 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(load);
    end
  end

endmodule

// File: tb/tb_ir_decode_queue.sv
// Scoreboard bench for ir_decode_queue: directed pushes queue hand-computed
// decode results, a negedge monitor compares them against each output handshake.
module tb_ir_decode_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic [31:0] out_signal;
  logic        out_illegal;
  logic        out_trap;
  logic        trap_hold;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] sig;
    logic        ill;
    logic        trap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pop_cyc[$];
  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;
  int   cyc      = 0;
  int   p0;

  ir_decode_queue #(.DEPTH(4), .PC_W(32), .SIG_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ir       (in_ir),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_pc      (out_pc),
    .out_signal  (out_signal),
    .out_illegal (out_illegal),
    .out_trap    (out_trap),
    .trap_hold   (trap_hold),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic nextDrive();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction until accepted; its expected decode enters the scoreboard.
  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] pc,
                               input logic [31:0] sig, input logic ill, input logic trap);
    exp_t e;
    int   budget;
    bit   done;
    in_valid = 1'b1;
    in_ir    = ir;
    in_pc    = pc;
    budget   = 20;
    done     = 1'b0;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (in_ready) begin
        e.ir = ir; e.pc = pc; e.sig = sig; e.ill = ill; e.trap = trap;
        exp_q.push_back(e);
        done = 1'b1;
      end
      nextDrive();
      budget--;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("push_timeout", 64'h0, 64'h1);
  endtask

  task automatic waitPops(input int target, input int budget);
    int b;
    b = budget;
    while (pops < target && b > 0) begin
      nextDrive();
      b--;
    end
    if (pops < target) checkOutput("drain_timeout", 64'(pops), 64'(target));
  endtask

  task automatic doFlush();
    flush = 1'b1;
    exp_q.delete();
    nextDrive();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_count", 64'(count), 64'h0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'h0);
    checkOutput("flush_trap_hold", 64'(trap_hold), 64'h0);
  endtask

  // Monitor: every handshake the DUT completes must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pop", 64'h1, 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pop_ir", 64'(out_ir), 64'(mon_e.ir));
        checkOutput("pop_pc", 64'(out_pc), 64'(mon_e.pc));
        checkOutput("pop_signal", 64'(out_signal), 64'(mon_e.sig));
        checkOutput("pop_illegal", 64'(out_illegal), 64'(mon_e.ill));
        checkOutput("pop_trap", 64'(out_trap), 64'(mon_e.trap));
      end
      pops++;
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    nextDrive();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'h1);
    checkOutput("reset_count", 64'(count), 64'h0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
    checkOutput("reset_out_signal", 64'(out_signal), 64'h0);
    checkOutput("reset_trap_hold", 64'(trap_hold), 64'h0);

    // Single add: accepted at edge 1, visible at edge 2, gone at edge 3
    nextDrive();
    out_ready = 1'b1;
    applyStimulus(32'h00221820, 32'h100, 32'h00000581, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lat_count", 64'(count), 64'h1);
    checkOutput("lat_out_valid_early", 64'(out_valid), 64'h0);
    nextDrive();
    @(negedge clk);
    checkOutput("lat_out_valid", 64'(out_valid), 64'h1);
    checkOutput("lat_out_signal", 64'(out_signal), 64'h581);
    checkOutput("lat_out_illegal", 64'(out_illegal), 64'h0);
    nextDrive();
    @(negedge clk);
    checkOutput("empty_drop_valid", 64'(out_valid), 64'h0);

    // Fill with out_ready low, then drain in order at one per cycle
    nextDrive();
    out_ready = 1'b0;
    applyStimulus(32'h00432022, 32'h110, 32'h00000681, 1'b0, 1'b0);
    applyStimulus(32'h8C450004, 32'h114, 32'h000005D8, 1'b0, 1'b0);
    applyStimulus(32'h84450002, 32'h118, 32'h002005D8, 1'b0, 1'b0);
    applyStimulus(32'h40026000, 32'h11C, 32'h00010080, 1'b0, 1'b0);
    applyStimulus(32'h40826000, 32'h120, 32'h00021000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_count", 64'(count), 64'h4);
    checkOutput("full_in_ready", 64'(in_ready), 64'h0);
    checkOutput("full_out_valid", 64'(out_valid), 64'h1);
    checkOutput("hold_out_ir", 64'(out_ir), 64'h00432022);
    nextDrive();
    p0 = pops;
    out_ready = 1'b1;
    applyStimulus(32'h0C000040, 32'h124, 32'h00002084, 1'b0, 1'b0);
    waitPops(p0 + 6, 30);
    if (pops >= p0 + 6)
      checkOutput("drain_rate", 64'(pop_cyc[p0 + 5] - pop_cyc[p0]), 64'h5);

    // Syscall consumed -> trap_hold, following add stays queued until flush
    out_ready = 1'b0;
    applyStimulus(32'h0000000C, 32'h200, 32'h00008000, 1'b0, 1'b1);
    applyStimulus(32'h00221820, 32'h204, 32'h00000581, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sys_out_valid", 64'(out_valid), 64'h1);
    checkOutput("sys_out_trap", 64'(out_trap), 64'h1);
    checkOutput("sys_count", 64'(count), 64'h1);
    nextDrive();
    out_ready = 1'b1;
    nextDrive();
    @(negedge clk);
    checkOutput("sys_trap_hold", 64'(trap_hold), 64'h1);
    checkOutput("sys_held_valid", 64'(out_valid), 64'h0);
    checkOutput("sys_held_count", 64'(count), 64'h1);
    repeat (3) nextDrive();
    @(negedge clk);
    checkOutput("sys_still_count", 64'(count), 64'h1);
    checkOutput("sys_still_valid", 64'(out_valid), 64'h0);
    nextDrive();
    applyStimulus(32'h34420001, 32'h208, 32'h000001C0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sys_accept_count", 64'(count), 64'h2);
    nextDrive();
    doFlush();

    // Illegal opcode, illegal func queued behind it, then eret
    nextDrive();
    out_ready = 1'b1;
    applyStimulus(32'hFC000000, 32'h300, 32'h00000000, 1'b1, 1'b1);
    nextDrive();
    @(negedge clk);
    checkOutput("ill_out_valid", 64'(out_valid), 64'h1);
    checkOutput("ill_out_illegal", 64'(out_illegal), 64'h1);
    checkOutput("ill_out_trap", 64'(out_trap), 64'h1);
    checkOutput("ill_out_signal", 64'(out_signal), 64'h0);
    nextDrive();
    @(negedge clk);
    checkOutput("ill_trap_hold", 64'(trap_hold), 64'h1);
    nextDrive();
    applyStimulus(32'h0000003F, 32'h304, 32'h00000000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("ill_queued_count", 64'(count), 64'h1);
    checkOutput("ill_queued_valid", 64'(out_valid), 64'h0);
    nextDrive();
    doFlush();
    nextDrive();
    p0 = pops;
    applyStimulus(32'h42000018, 32'h308, 32'h00040000, 1'b0, 1'b1);
    waitPops(p0 + 1, 10);
    @(negedge clk);
    checkOutput("eret_trap_hold", 64'(trap_hold), 64'h1);
    nextDrive();
    doFlush();

    // Flush with a full queue and in_valid high: nothing is pushed
    nextDrive();
    out_ready = 1'b0;
    applyStimulus(32'h10220003, 32'h400, 32'h00000602, 1'b0, 1'b0);
    applyStimulus(32'h14220003, 32'h404, 32'h00080602, 1'b0, 1'b0);
    applyStimulus(32'h20420005, 32'h408, 32'h000005C0, 1'b0, 1'b0);
    applyStimulus(32'h38420003, 32'h40C, 32'h000002C0, 1'b0, 1'b0);
    applyStimulus(32'hAC450008, 32'h410, 32'h00000560, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre_flush_count", 64'(count), 64'h4);
    checkOutput("pre_flush_valid", 64'(out_valid), 64'h1);
    nextDrive();
    flush = 1'b1; in_valid = 1'b1; in_ir = 32'h00221820; in_pc = 32'h414; out_ready = 1'b1;
    exp_q.delete();
    nextDrive();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checkOutput("flushfull_count", 64'(count), 64'h0);
    checkOutput("flushfull_valid", 64'(out_valid), 64'h0);
    nextDrive();
    @(negedge clk);
    checkOutput("flushfull_count2", 64'(count), 64'h0);
    checkOutput("flushfull_valid2", 64'(out_valid), 64'h0);

    // Reset in the middle of traffic
    nextDrive();
    applyStimulus(32'h00221820, 32'h500, 32'h00000581, 1'b0, 1'b0);
    applyStimulus(32'h00432022, 32'h504, 32'h00000681, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mid_out_valid", 64'(out_valid), 64'h1);
    checkOutput("mid_count", 64'(count), 64'h1);
    nextDrive();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'h0);
    nextDrive();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_valid", 64'(out_valid), 64'h0);
    checkOutput("post_rst_ir", 64'(out_ir), 64'h0);
    checkOutput("post_rst_pc", 64'(out_pc), 64'h0);
    checkOutput("post_rst_signal", 64'(out_signal), 64'h0);
    checkOutput("post_rst_illegal", 64'(out_illegal), 64'h0);
    checkOutput("post_rst_trap", 64'(out_trap), 64'h0);
    checkOutput("post_rst_count", 64'(count), 64'h0);
    checkOutput("post_rst_trap_hold", 64'(trap_hold), 64'h0);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'h1);

    checkOutput("total_pops", 64'(pops), 64'd10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
